// File: rtl/spm_serdes.sv
// Host-side operand loader and product collector for the serial-parallel multiplier array.
// The multiplicand is held parallel on x_out while y is streamed LSB-first and product bits are captured.
module spm_serdes #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int LAT    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic [WIDTH-1:0]     x_out,
  output logic                 y_out,
  output logic                 spm_clr,
  input  logic                 p_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready=1
  // CLEAR | one cycle clearing the spm array and capture register
  // SHIFT | streaming y bits out, sampling product bits in
  // DONE  | product presented until out_ready

  localparam int PW   = 2 * WIDTH;
  localparam int LAST = PW + LAT - 1;
  localparam int CW   = $clog2(PW + LAT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   y_sr;
  logic [PW-1:0]   cap;
  logic [PW-1:0]   y_ext;
  logic            y_sgn;
  logic            accept;
  logic            last;
  logic            sample;

  assign y_sgn  = SIGNED && in_y[WIDTH-1];
  assign y_ext  = {{WIDTH{y_sgn}}, in_y};
  assign accept = in_valid && in_ready;
  assign last   = (int'(cnt) == LAST);
  assign sample = (int'(cnt) >= LAT);
  assign out_p  = cap;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CLEAR;
      end
      CLEAR: state_nx = SHIFT;
      SHIFT: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      y_sr    <= '0;
      cap     <= '0;
      x_out   <= '0;
      y_out   <= 1'b0;
      spm_clr <= 1'b1;
    end else begin
      state   <= state_nx;
      spm_clr <= (state_nx == CLEAR);
      case (state)
        IDLE: begin
          if (accept) begin
            x_out <= in_x;
            y_sr  <= y_ext;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          cap   <= '0;
          y_out <= y_sr[0];
          y_sr  <= {1'b0, y_sr[PW-1:1]};
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          // Zero-filled shift register drives y_out low once all 2*WIDTH bits are gone.
          if (sample) cap <= {p_in, cap[PW-1:1]};
          y_out <= last ? 1'b0 : y_sr[0];
          y_sr  <= {1'b0, y_sr[PW-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spm_serdes.md
# spm_serdes

Host-side driver and collector for the serial-parallel multiplier (`spm`) array of carry-save cells. It accepts a parallel operand pair over a valid/ready handshake and holds the multiplicand `x` parallel to the array. It shifts the multiplier `y` into the array LSB-first, with sign extension when configured signed. It then deserializes the returned serial product bits into a parallel 2·WIDTH result with its own valid/ready handshake. It sits between the system bus side and the `spm` core; it is the other end of the serial `y`/`p` bit interface the `spm` cells consume and produce.

## Interface
- WIDTH, 32, width of `x` and `y` operands; product is 2·WIDTH bits
- SIGNED, 1, 1 = two's-complement operands (y sign-extended), 0 = unsigned (zero-extended)
- LAT, 0, cycles between driving y bit k on `y_out` and the matching product bit k on `p_in` (0..3)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising edge)
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_x  in  WIDTH  multiplicand
- in_y  in  WIDTH  multiplier
- x_out  out  WIDTH  registered multiplicand to `spm`, stable for the whole operation
- y_out  out  1  registered serial multiplier bit to `spm`
- spm_clr  out  1  clears `spm` carry/sum state
- p_in  in  1  serial product bit from `spm`
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  2·WIDTH  product

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_x into x_out and in_y into the y shift register. Go to CLEAR.
- CLEAR: one cycle, spm_clr=1, y_out=0. Clear the bit counter c and the capture register. Go to SHIFT.
- SHIFT: runs for c = 0 .. 2·WIDTH+LAT−1, and c increments each cycle.
  - y_out = y[c] for c<WIDTH.
  - For WIDTH≤c<2·WIDTH, y_out = y[WIDTH−1] if SIGNED, else 0.
  - For c≥2·WIDTH, y_out = 0.
  - When c≥LAT, sample p_in into the capture register: right shift, new bit enters at MSB. After 2·WIDTH samples, bit 0 is product bit 0.
  - On the last count, go to DONE.
- DONE: out_valid=1 and out_p = captured product, held stable. On out_ready, go to IDLE.
- The product is exact modulo 2^(2·WIDTH). No saturation.
- in_ready is 0 in CLEAR, SHIFT and DONE. Operands presented then are not accepted and must be held by the producer.
- x_out retains its last value in IDLE. It changes only on acceptance.
- spm_clr is 1 whenever rst=0 and in CLEAR, and 0 otherwise.

## Timing
- Reset values, on the first edge with rst=0 and held while rst=0: state IDLE, in_ready=1, out_valid=0, out_p=0, x_out=0, y_out=0, spm_clr=1, counter 0.
- Reset mid-operation (any state) aborts immediately. No partial result is presented, and out_valid=0 on the next cycle.
- Accept edge = cycle 0. CLEAR occupies cycle 1. SHIFT occupies cycles 2 .. 2·WIDTH+LAT+1. out_valid rises at cycle 2·WIDTH+LAT+2.
- Minimum accept-to-accept spacing is 2·WIDTH+LAT+3 cycles, reached with out_ready held high.
- In DONE with out_ready=1, in_ready rises the following cycle (IDLE). There is no same-cycle out-to-in bypass.
- out_valid, once high, stays high with out_p unchanged until out_ready is sampled high, regardless of how long the stall lasts.
- in_valid may drop while in_ready=0 without effect. Acceptance requires both in_valid and in_ready high on the same edge.
- y_out and spm_clr are registered. The `spm` sees the first y bit in the cycle after CLEAR.

## Test plan
- WIDTH=8, SIGNED=1, LAT=0: x=3, y=5 -> out_p=0x000F, out_valid at cycle 18 after accept.
- WIDTH=8, SIGNED=1: x=−3 (0xFD), y=5 -> 0xFFF1. Also x=−128, y=−128 (0x80, 0x80) -> 0x4000.
- WIDTH=8, SIGNED=0: x=0xFF, y=0xFF -> 0xFE01. During cycles 10..17, y_out=0 (no sign extension).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_p constant and in_ready=0 throughout. On release, in_ready=1 next cycle. A back-to-back second operation (x=7, y=−2) -> 0xFFF2.
- Reset mid-SHIFT: drive rst=0 at SHIFT cycle 6 for one cycle -> next cycle state IDLE, out_valid=0, spm_clr was 1 during reset. A new operation x=2, y=9 then -> 0x0012.
- LAT=2, with the model `spm` delaying p by 2 cycles: x=−1, y=−1 -> 0x0001, and out_valid arrives 2 cycles later than with LAT=0.
